// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the RISC-V unified memory arbiter.
// Owner encoding and tag layout are common to the arbiter and its tag pipeline.
package riscv_mem_pkg;

   localparam int MEM_ADDR_W = 14;
   localparam int MEM_LAT    = 2;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } mem_owner_t;

   typedef struct packed {
      logic       valid;
      mem_owner_t owner;
   } mem_tag_t;

endpackage

// File: rtl/riscv_mem_tag_pipe.sv
// LAT-deep shift register of read tags; the last stage lines up with BRAM read data.
// Stage 0 is reloaded every cycle, so a bubble simply carries valid=0.
module riscv_mem_tag_pipe
   import riscv_mem_pkg::*;
#(
   parameter int LAT = MEM_LAT
) (
   input  logic     clk_100mhz,
   input  logic     rst_in,
   input  mem_tag_t tag_in,
   output mem_tag_t tag_out
);

   mem_tag_t stage_q [LAT];

   // NOTE: this small tag register is reset because a stale valid bit would fire a spurious response; bulk data RAM needs no reset.
   always_ff @(posedge clk_100mhz or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_in;
         for (int i = 1; i < LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port, fixed-latency BRAM between instruction fetch (IF) and data memory (DM).
// Define MEM_ARB_ROUND_ROBIN_EN to alternate ties between requesters; default is fixed DM priority.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = 32,
   parameter int LAT    = MEM_LAT
) (
   input  logic                  clk_100mhz,
   input  logic                  rst_in,
   input  logic                  if_req_in,
   input  logic [ADDR_W-1:0]     if_addr_in,
   output logic                  if_ready_out,
   output logic                  if_rvalid_out,
   output logic [DATA_W-1:0]     if_rdata_out,
   input  logic                  dm_req_in,
   input  logic                  dm_we_in,
   input  logic [DATA_W/8-1:0]   dm_be_in,
   input  logic [ADDR_W-1:0]     dm_addr_in,
   input  logic [DATA_W-1:0]     dm_wdata_in,
   output logic                  dm_ready_out,
   output logic                  dm_rvalid_out,
   output logic [DATA_W-1:0]     dm_rdata_out,
   output logic                  bram_en_out,
   output logic [DATA_W/8-1:0]   bram_we_out,
   output logic [ADDR_W-1:0]     bram_addr_out,
   output logic [DATA_W-1:0]     bram_wdata_out,
   input  logic [DATA_W-1:0]     bram_rdata_in
);

   logic              grant_if;
   logic              grant_dm;
   logic              dm_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   mem_tag_t          tag_in;
   mem_tag_t          tag_out;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   mem_owner_t        last_grant_q;
`endif

   // NOTE: every always_comb output is given a default first so no path can infer a latch.
   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (!rst_in) begin
         if (if_req_in && dm_req_in) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_if = (last_grant_q == OWNER_DM);
            grant_dm = (last_grant_q == OWNER_IF);
`else
            grant_dm = 1'b1;
`endif
         end else begin
            grant_if = if_req_in;
            grant_dm = dm_req_in;
         end
      end
   end

   assign if_ready_out = grant_if;
   assign dm_ready_out = grant_dm;
   assign dm_write     = grant_dm && dm_we_in;
   assign sel_addr     = grant_dm ? dm_addr_in : if_addr_in;

   // Idle cycles replay the last address/wdata so the BRAM pins do not toggle needlessly.
   assign bram_en_out    = grant_if || grant_dm;
   assign bram_we_out    = dm_write ? dm_be_in : '0;
   assign bram_addr_out  = bram_en_out ? sel_addr : addr_q;
   assign bram_wdata_out = dm_write ? dm_wdata_in : wdata_q;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_100mhz or posedge rst_in) begin
      if (rst_in) begin
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (bram_en_out) begin
            addr_q <= sel_addr;
         end
         if (dm_write) begin
            wdata_q <= dm_wdata_in;
         end
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Reset to IF so DM wins the first tie.
   always_ff @(posedge clk_100mhz or posedge rst_in) begin
      if (rst_in) begin
         last_grant_q <= OWNER_IF;
      end else if (grant_dm) begin
         last_grant_q <= OWNER_DM;
      end else if (grant_if) begin
         last_grant_q <= OWNER_IF;
      end
   end
`endif

   always_comb begin
      tag_in       = '0;
      tag_in.valid = grant_if || (grant_dm && !dm_we_in);
      tag_in.owner = grant_dm ? OWNER_DM : OWNER_IF;
   end

   riscv_mem_tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk_100mhz (clk_100mhz),
      .rst_in     (rst_in),
      .tag_in     (tag_in),
      .tag_out    (tag_out)
   );

   // Response register adds one cycle, so rvalid lands LAT+1 cycles after the accept.
   always_ff @(posedge clk_100mhz or posedge rst_in) begin
      if (rst_in) begin
         if_rvalid_out <= 1'b0;
         dm_rvalid_out <= 1'b0;
         if_rdata_out  <= '0;
         dm_rdata_out  <= '0;
      end else begin
         if_rvalid_out <= tag_out.valid && (tag_out.owner == OWNER_IF);
         dm_rvalid_out <= tag_out.valid && (tag_out.owner == OWNER_DM);
         if (tag_out.valid && (tag_out.owner == OWNER_IF)) begin
            if_rdata_out <= bram_rdata_in;
         end
         if (tag_out.valid && (tag_out.owner == OWNER_DM)) begin
            dm_rdata_out <= bram_rdata_in;
         end
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model and a write-first BRAM model.
module tb_riscv_mem_arbiter;
   import riscv_mem_pkg::*;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
   localparam int LAT    = MEM_LAT;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk_100mhz = 1'b0;
   logic              rst_in     = 1'b0;
   logic              if_req_in  = 1'b0;
   logic [ADDR_W-1:0] if_addr_in = '0;
   logic              if_ready_out;
   logic              if_rvalid_out;
   logic [DATA_W-1:0] if_rdata_out;
   logic              dm_req_in   = 1'b0;
   logic              dm_we_in    = 1'b0;
   logic [BE_W-1:0]   dm_be_in    = '0;
   logic [ADDR_W-1:0] dm_addr_in  = '0;
   logic [DATA_W-1:0] dm_wdata_in = '0;
   logic              dm_ready_out;
   logic              dm_rvalid_out;
   logic [DATA_W-1:0] dm_rdata_out;
   logic              bram_en_out;
   logic [BE_W-1:0]   bram_we_out;
   logic [ADDR_W-1:0] bram_addr_out;
   logic [DATA_W-1:0] bram_wdata_out;
   logic [DATA_W-1:0] bram_rdata_in;

   riscv_mem_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LAT    (LAT)
   ) dut (
      .clk_100mhz     (clk_100mhz),
      .rst_in         (rst_in),
      .if_req_in      (if_req_in),
      .if_addr_in     (if_addr_in),
      .if_ready_out   (if_ready_out),
      .if_rvalid_out  (if_rvalid_out),
      .if_rdata_out   (if_rdata_out),
      .dm_req_in      (dm_req_in),
      .dm_we_in       (dm_we_in),
      .dm_be_in       (dm_be_in),
      .dm_addr_in     (dm_addr_in),
      .dm_wdata_in    (dm_wdata_in),
      .dm_ready_out   (dm_ready_out),
      .dm_rvalid_out  (dm_rvalid_out),
      .dm_rdata_out   (dm_rdata_out),
      .bram_en_out    (bram_en_out),
      .bram_we_out    (bram_we_out),
      .bram_addr_out  (bram_addr_out),
      .bram_wdata_out (bram_wdata_out),
      .bram_rdata_in  (bram_rdata_in)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   int cyc = 0;
   always @(posedge clk_100mhz) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] init_word(input int a);
      if (a == 'h10)  return 32'hDEADBEEF;
      if (a == 'h200) return 32'h11223344;
      return (32'(a) * 32'h9E3779B1) ^ 32'h13572468;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 14'h3FF0 + 14'($urandom_range(0, 15));
      return 14'($urandom_range(0, 31));
   endfunction

   // BRAM model, reference memory, pending-response queue and observed-response log
   logic [31:0] bmem    [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] bpipe   [LAT+1];
   assign bram_rdata_in = bpipe[LAT];

   typedef struct { int due; bit dm; logic [31:0] data; } pend_t;
   typedef struct { int cyc; bit dm; logic [31:0] data; } ev_t;
   pend_t pend_q[$];
   ev_t   ev_q[$];

   bit                if_acc, dm_acc;
   logic [31:0]       exp_if_rdata, exp_dm_rdata;
   bit                last_dm, have_addr;
   logic [ADDR_W-1:0] last_addr;

   task automatic model_step();
      bit    g_if, g_dm, exp_if_v, exp_dm_v;
      pend_t p;
      if (rst_in) begin
         pend_q.delete();
         exp_if_rdata = '0;
         exp_dm_rdata = '0;
         last_dm      = 1'b0;
         have_addr    = 1'b0;
         check("m_rst_if_ready",  64'(if_ready_out),  64'd0);
         check("m_rst_dm_ready",  64'(dm_ready_out),  64'd0);
         check("m_rst_bram_en",   64'(bram_en_out),   64'd0);
         check("m_rst_bram_we",   64'(bram_we_out),   64'd0);
         check("m_rst_if_rvalid", 64'(if_rvalid_out), 64'd0);
         check("m_rst_dm_rvalid", 64'(dm_rvalid_out), 64'd0);
         check("m_rst_if_rdata",  64'(if_rdata_out),  64'd0);
         check("m_rst_dm_rdata",  64'(dm_rdata_out),  64'd0);
         return;
      end
      if (if_req_in && dm_req_in) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         g_dm = !last_dm;
`else
         g_dm = 1'b1;
`endif
         g_if = !g_dm;
      end else begin
         g_if = if_req_in;
         g_dm = dm_req_in;
      end
      check("m_if_ready", 64'(if_ready_out), 64'(g_if));
      check("m_dm_ready", 64'(dm_ready_out), 64'(g_dm));
      check("m_bram_en",  64'(bram_en_out),  64'(g_if || g_dm));
      check("m_bram_we",  64'(bram_we_out),  64'((g_dm && dm_we_in) ? dm_be_in : 4'b0));
      if (g_if || g_dm) begin
         last_addr = g_dm ? dm_addr_in : if_addr_in;
         have_addr = 1'b1;
         check("m_bram_addr", 64'(bram_addr_out), 64'(last_addr));
      end else if (have_addr) begin
         check("m_bram_addr_hold", 64'(bram_addr_out), 64'(last_addr));
      end
      if (g_dm && dm_we_in) check("m_bram_wdata", 64'(bram_wdata_out), 64'(dm_wdata_in));

      exp_if_v = 1'b0;
      exp_dm_v = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         p = pend_q.pop_front();
         if (p.dm) begin exp_dm_v = 1'b1; exp_dm_rdata = p.data; end
         else      begin exp_if_v = 1'b1; exp_if_rdata = p.data; end
      end
      check("m_if_rvalid", 64'(if_rvalid_out), 64'(exp_if_v));
      check("m_dm_rvalid", 64'(dm_rvalid_out), 64'(exp_dm_v));
      check("m_if_rdata",  64'(if_rdata_out),  64'(exp_if_rdata));
      check("m_dm_rdata",  64'(dm_rdata_out),  64'(exp_dm_rdata));

      if (g_if) pend_q.push_back('{cyc + LAT + 1, 1'b0, ref_mem[if_addr_in]});
      else if (g_dm && !dm_we_in) pend_q.push_back('{cyc + LAT + 1, 1'b1, ref_mem[dm_addr_in]});
      else if (g_dm) ref_mem[dm_addr_in] = merge(ref_mem[dm_addr_in], dm_wdata_in, dm_be_in);
      if (g_if || g_dm) last_dm = g_dm;
   endtask

   // Write-first BRAM: data read at negedge of the address cycle reaches the output LAT cycles later.
   task automatic bram_step();
      logic [31:0] w;
      for (int i = LAT; i > 0; i--) bpipe[i] = bpipe[i-1];
      if (bram_en_out) begin
         w = merge(bmem[bram_addr_out], bram_wdata_out, bram_we_out);
         bmem[bram_addr_out] = w;
         bpipe[0] = w;
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         bmem[i]    = init_word(i);
         ref_mem[i] = init_word(i);
      end
      for (int i = 0; i <= LAT; i++) bpipe[i] = '0;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      last_dm      = 1'b0;
      have_addr    = 1'b0;
      last_addr    = '0;
      forever begin
         @(negedge clk_100mhz);
         if (if_rvalid_out) ev_q.push_back('{cyc, 1'b0, if_rdata_out});
         if (dm_rvalid_out) ev_q.push_back('{cyc, 1'b1, dm_rdata_out});
         if_acc = if_req_in && if_ready_out;
         dm_acc = dm_req_in && dm_ready_out;
         model_step();
         bram_step();
      end
   end

   task automatic tick();
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic check_ev(input string tag, input int idx, input int exp_cyc,
                           input bit exp_dm, input logic [31:0] exp_data);
      check({tag, "_present"}, 64'(ev_q.size() > idx), 64'd1);
      if (ev_q.size() > idx) begin
         check({tag, "_cycle"}, 64'(ev_q[idx].cyc),  64'(exp_cyc));
         check({tag, "_port"},  64'(ev_q[idx].dm),   64'(exp_dm));
         check({tag, "_data"},  64'(ev_q[idx].data), 64'(exp_data));
      end
   endtask

   task automatic if_only_read(input string tag);
      int c0;
      ev_q.delete();
      if_req_in  = 1'b1;
      if_addr_in = 14'h0010;
      c0 = cyc;
      @(negedge clk_100mhz);
      check({tag, "_if_ready"},  64'(if_ready_out),  64'd1);
      check({tag, "_dm_ready"},  64'(dm_ready_out),  64'd0);
      check({tag, "_bram_addr"}, 64'(bram_addr_out), 64'h10);
      tick();
      if_req_in = 1'b0;
      repeat (5) tick();
      check({tag, "_resp_count"}, 64'(ev_q.size()), 64'd1);
      check_ev({tag, "_ev0"}, 0, c0 + 3, 1'b0, 32'hDEADBEEF);
   endtask

   initial begin
      int c0;
      #1 rst_in = 1'b1;
      repeat (2) tick();
      @(negedge clk_100mhz);
      check("rst_bram_en",   64'(bram_en_out),   64'd0);
      check("rst_if_rvalid", 64'(if_rvalid_out), 64'd0);
      check("rst_dm_rdata",  64'(dm_rdata_out),  64'd0);
      tick();
      rst_in = 1'b0;
      tick();

      if_only_read("if_only");

      // Two consecutive ties, then the leftover requester
      ev_q.delete();
      c0 = cyc;
      if_req_in = 1'b1; if_addr_in = 14'h0004;
      dm_req_in = 1'b1; dm_we_in = 1'b0; dm_addr_in = 14'h0100;
      @(negedge clk_100mhz);
      check("tie1_dm_ready", 64'(dm_ready_out), 64'd1);
      check("tie1_if_ready", 64'(if_ready_out), 64'd0);
      tick();
      dm_addr_in = 14'h0104;
      @(negedge clk_100mhz);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("tie2_if_ready", 64'(if_ready_out), 64'd1);
      check("tie2_dm_ready", 64'(dm_ready_out), 64'd0);
      tick();
      if_req_in = 1'b0;
      @(negedge clk_100mhz);
      check("tie3_dm_ready", 64'(dm_ready_out), 64'd1);
`else
      check("tie2_dm_ready", 64'(dm_ready_out), 64'd1);
      check("tie2_if_ready", 64'(if_ready_out), 64'd0);
      tick();
      dm_req_in = 1'b0;
      @(negedge clk_100mhz);
      check("tie3_if_ready", 64'(if_ready_out), 64'd1);
`endif
      tick();
      if_req_in = 1'b0;
      dm_req_in = 1'b0;
      repeat (5) tick();
      check("tie_resp_count", 64'(ev_q.size()), 64'd3);
      check_ev("tie_ev0", 0, c0 + 3, 1'b1, init_word('h100));
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check_ev("tie_ev1", 1, c0 + 4, 1'b0, init_word('h004));
      check_ev("tie_ev2", 2, c0 + 5, 1'b1, init_word('h104));
`else
      check_ev("tie_ev1", 1, c0 + 4, 1'b1, init_word('h104));
      check_ev("tie_ev2", 2, c0 + 5, 1'b0, init_word('h004));
`endif

      // Byte write into 0x11223344, then read back the next cycle
      ev_q.delete();
      c0 = cyc;
      dm_req_in = 1'b1; dm_we_in = 1'b1; dm_be_in = 4'b0010;
      dm_addr_in = 14'h0200; dm_wdata_in = 32'h0000AB00;
      @(negedge clk_100mhz);
      check("bw_bram_en",    64'(bram_en_out),    64'd1);
      check("bw_bram_we",    64'(bram_we_out),    64'b0010);
      check("bw_bram_wdata", 64'(bram_wdata_out), 64'h0000AB00);
      tick();
      dm_we_in = 1'b0;
      @(negedge clk_100mhz);
      check("bw_read_we", 64'(bram_we_out), 64'd0);
      tick();
      dm_req_in = 1'b0;
      repeat (5) tick();
      check("bw_resp_count", 64'(ev_q.size()), 64'd1);
      check_ev("bw_ev0", 0, c0 + 4, 1'b1, 32'h1122AB44);

      // Back-to-back IF, DM, IF reads
      ev_q.delete();
      c0 = cyc;
      if_req_in = 1'b1; if_addr_in = 14'h0020;
      tick();
      if_req_in = 1'b0;
      dm_req_in = 1'b1; dm_we_in = 1'b0; dm_addr_in = 14'h0021;
      tick();
      dm_req_in = 1'b0;
      if_req_in = 1'b1; if_addr_in = 14'h0022;
      tick();
      if_req_in = 1'b0;
      repeat (5) tick();
      check("b2b_resp_count", 64'(ev_q.size()), 64'd3);
      check_ev("b2b_ev0", 0, c0 + 3, 1'b0, init_word('h20));
      check_ev("b2b_ev1", 1, c0 + 4, 1'b1, init_word('h21));
      check_ev("b2b_ev2", 2, c0 + 5, 1'b0, init_word('h22));

      // Reset one cycle after a DM read is accepted
      ev_q.delete();
      dm_req_in = 1'b1; dm_we_in = 1'b0; dm_addr_in = 14'h0030;
      tick();
      dm_req_in = 1'b0;
      if_req_in = 1'b1;
      rst_in    = 1'b1;
      @(negedge clk_100mhz);
      check("rmf_if_ready",  64'(if_ready_out),  64'd0);
      check("rmf_dm_ready",  64'(dm_ready_out),  64'd0);
      check("rmf_bram_en",   64'(bram_en_out),   64'd0);
      check("rmf_bram_we",   64'(bram_we_out),   64'd0);
      check("rmf_if_rvalid", 64'(if_rvalid_out), 64'd0);
      check("rmf_dm_rvalid", 64'(dm_rvalid_out), 64'd0);
      check("rmf_if_rdata",  64'(if_rdata_out),  64'd0);
      check("rmf_dm_rdata",  64'(dm_rdata_out),  64'd0);
      tick();
      tick();
      if_req_in = 1'b0;
      rst_in    = 1'b0;
      repeat (6) tick();
      check("rmf_no_resp", 64'(ev_q.size()), 64'd0);
      if_only_read("post_rst");

      // Randomized traffic; requesters hold until accepted
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (i == 1500) rst_in = 1'b1;
         if (i == 1503) rst_in = 1'b0;
         if (!if_req_in || if_acc) begin
            if_req_in  = ($urandom_range(0, 99) < 55);
            if_addr_in = rand_addr();
         end
         if (!dm_req_in || dm_acc) begin
            dm_req_in   = ($urandom_range(0, 99) < 55);
            dm_we_in    = ($urandom_range(0, 2) == 0);
            dm_be_in    = 4'($urandom);
            dm_addr_in  = rand_addr();
            dm_wdata_in = $urandom;
         end
      end
      tick();
      if_req_in = 1'b0;
      dm_req_in = 1'b0;
      repeat (8) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
